// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D sweep scheduler.
package a2d_pkg;

  localparam int unsigned RES_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    START,
    ARM,
    WAIT,
    STORE
  } sched_state_t;

  // Channel converted for each list index; index 0 is element 0.
  localparam logic [2:0] SWEEP_ORDER [8] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7, 3'd5, 3'd6};

endpackage

// File: rtl/sched_timer.sv
// Loadable up-counter with synchronous clear, count enable and terminal-count compare.
module sched_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             ld_i,
  input  logic [Width-1:0] ld_val_i,
  input  logic [Width-1:0] tc_val_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/a2d_sweep_sched.sv
// Walks the A2D interface through SWEEP_ORDER once per go, with a settle delay per entry,
// and presents each captured result with its list index.
module a2d_sweep_sched
  import a2d_pkg::*;
#(
  parameter int unsigned NUM_CH      = 6,
  parameter int unsigned SETTLE_CYC  = 4096,
  parameter int unsigned TIMEOUT_CYC = 8192
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             cnv_cmplt,
  input  logic [RES_W-1:0] res,
  output logic             strt_cnv,
  output logic [2:0]       chnnl,
  output logic [RES_W-1:0] rslt,
  output logic [2:0]       rslt_idx,
  output logic             rslt_vld,
  output logic             sweep_done,
  output logic             sweep_err,
  output logic             busy
);

  localparam int unsigned MaxCyc  = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int unsigned CntW    = $clog2(MaxCyc) + 1;
  localparam logic [2:0]  LastIdx = 3'(NUM_CH - 1);

  sched_state_t     state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       chnnl_q, chnnl_d;
  logic [RES_W-1:0] rslt_q, rslt_d;
  logic [2:0]       rslt_idx_q, rslt_idx_d;
  logic             rslt_vld_q, rslt_vld_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic settle_clr, settle_en, settle_tc;
  logic to_clr, to_en, to_tc;

  sched_timer #(
    .Width (CntW)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (settle_clr),
    .en_i     (settle_en),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .tc_val_i (CntW'(SETTLE_CYC - 1)),
    .tc_o     (settle_tc)
  );

  sched_timer #(
    .Width (CntW)
  ) u_timeout_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (to_clr),
    .en_i     (to_en),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .tc_val_i (CntW'(TIMEOUT_CYC - 1)),
    .tc_o     (to_tc)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rslt_d     = rslt_q;
    rslt_idx_d = rslt_idx_q;
    rslt_vld_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    settle_clr = 1'b1;
    settle_en  = 1'b0;
    to_clr     = 1'b1;
    to_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The done/err pulse shows while already in IDLE; the sweep is not over until it drops.
        if (go && !done_q && !err_q) begin
          state_d = SETTLE;
          idx_d   = '0;
        end
      end
      SETTLE: begin
        settle_clr = 1'b0;
        settle_en  = 1'b1;
        if (settle_tc) begin
          state_d = START;
        end
      end
      START: state_d = ARM;
      ARM:   state_d = WAIT;
      WAIT: begin
        to_clr = 1'b0;
        to_en  = 1'b1;
        if (cnv_cmplt) begin
          state_d = STORE;
        end else if (to_tc) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      STORE: begin
        rslt_d     = res;
        rslt_idx_d = idx_q;
        rslt_vld_d = 1'b1;
        if (idx_q == LastIdx) begin
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase

    chnnl_d = SWEEP_ORDER[idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      chnnl_q    <= SWEEP_ORDER[0];
      rslt_q     <= '0;
      rslt_idx_q <= '0;
      rslt_vld_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      chnnl_q    <= chnnl_d;
      rslt_q     <= rslt_d;
      rslt_idx_q <= rslt_idx_d;
      rslt_vld_q <= rslt_vld_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign strt_cnv   = (state_q == START);
  assign busy       = (state_q != IDLE);
  assign chnnl      = chnnl_q;
  assign rslt       = rslt_q;
  assign rslt_idx   = rslt_idx_q;
  assign rslt_vld   = rslt_vld_q;
  assign sweep_done = done_q;
  assign sweep_err  = err_q;

endmodule

// File: tb/tb_a2d_sweep_sched.sv
// Scoreboard bench for a2d_sweep_sched with a behavioural A2D interface model.
module tb_a2d_sweep_sched;

  localparam int unsigned NCH   = 6;
  localparam int unsigned SCYC  = 16;
  localparam int unsigned TCYC  = 40;
  localparam int unsigned CLAT  = 3;
  localparam int          LIMIT = 2000;

  typedef struct packed {
    logic        err;
    logic [2:0]  idx;
    logic [11:0] rslt;
    logic        done;
  } exp_t;

  logic [2:0] order [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] rslt;
  logic [2:0]  rslt_idx;
  logic        rslt_vld, sweep_done, sweep_err, busy;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb [$];

  // A2D model state
  logic        m_busy = 1'b0;
  logic        m_stalled = 1'b0;
  int          m_lat = 0;
  logic [11:0] m_res = '0;
  logic [3:0]  stall_ch = 4'd8;
  logic        model_kill = 1'b0;

  a2d_sweep_sched #(
    .NUM_CH      (NCH),
    .SETTLE_CYC  (SCYC),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .cnv_cmplt  (cnv_cmplt),
    .res        (res),
    .strt_cnv   (strt_cnv),
    .chnnl      (chnnl),
    .rslt       (rslt),
    .rslt_idx   (rslt_idx),
    .rslt_vld   (rslt_vld),
    .sweep_done (sweep_done),
    .sweep_err  (sweep_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign cnv_cmplt = !(strt_cnv || m_busy);
  assign res       = m_res;

  always @(posedge clk) begin
    if (model_kill) begin
      m_busy    <= 1'b0;
      m_stalled <= 1'b0;
    end else if (strt_cnv) begin
      m_busy    <= 1'b1;
      m_lat     <= CLAT;
      m_res     <= 12'hA00 + {9'd0, chnnl};
      m_stalled <= ({1'b0, chnnl} == stall_ch);
    end else if (m_busy && !m_stalled) begin
      if (m_lat == 0) m_busy <= 1'b0;
      else            m_lat  <= m_lat - 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: every result or error pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && (rslt_vld || sweep_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_is_err", int'(sweep_err), int'(e.err));
        check("out_is_vld", int'(rslt_vld), int'(!e.err));
        if (!e.err) begin
          check("rslt", int'(rslt), int'(e.rslt));
          check("rslt_idx", int'(rslt_idx), int'(e.idx));
          check("done_with_vld", int'(sweep_done), int'(e.done));
        end
      end
    end
  end

  task automatic push_sweep(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.err  = 1'b0;
      e.idx  = 3'(i);
      e.rslt = 12'hA00 + {9'd0, order[i]};
      e.done = (i == int'(NCH) - 1);
      sb.push_back(e);
    end
  endtask

  task automatic push_err();
    exp_t e;
    e = '0;
    e.err = 1'b1;
    sb.push_back(e);
  endtask

  // Counts from start_k for the current cycle; returns LIMIT on expiry.
  task automatic wait_strt(input int start_k, output int k);
    k = start_k;
    while (!strt_cnv && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    if (!strt_cnv) check("strt_cnv_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!sweep_done && k < LIMIT * 8) begin
      @(negedge clk);
      k++;
    end
    if (!sweep_done) check("sweep_done_timeout", 0, 1);
  endtask

  task automatic kill_model();
    @(negedge clk);
    model_kill = 1'b1;
    @(negedge clk);
    model_kill = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int strt_seen;
    int busy_seen;

    // 1: reset, idle for 100 cycles
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    strt_seen = 0;
    busy_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (strt_cnv) strt_seen++;
      if (busy) busy_seen++;
    end
    check("idle_strt_pulses", strt_seen, 0);
    check("idle_busy_cycles", busy_seen, 0);
    check("reset_rslt", int'(rslt), 0);
    check("reset_rslt_idx", int'(rslt_idx), 0);
    check("reset_chnnl", int'(chnnl), 1);
    check("reset_vld", int'(rslt_vld), 0);
    check("reset_done", int'(sweep_done), 0);
    check("reset_err", int'(sweep_err), 0);

    // 2/3: full sweep with latency measurements
    @(negedge clk);
    go = 1'b1;
    push_sweep(NCH);
    @(negedge clk);
    go = 1'b0;
    check("busy_after_go", int'(busy), 1);
    wait_strt(1, k);
    check("go_to_strt_cycles", k, SCYC + 1);
    check("first_chnnl", int'(chnnl), 1);
    k = 0;
    while (!cnv_cmplt && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    wait_strt(1, k);
    check("cmplt_to_next_strt", k, SCYC + 2);
    check("second_chnnl", int'(chnnl), 0);
    wait_done();
    check("busy_at_done", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("sb_empty_sweep", sb.size(), 0);

    // 4: entry 2 never completes
    stall_ch = 4'd4;
    @(negedge clk);
    go = 1'b1;
    push_sweep(2);
    push_err();
    @(negedge clk);
    go = 1'b0;
    wait_strt(1, k);
    @(negedge clk);
    wait_strt(1, k);
    @(negedge clk);
    wait_strt(1, k);
    check("stall_chnnl", int'(chnnl), 4);
    k = 0;
    while (!sweep_err && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    check("strt_to_err_cycles", k, TCYC + 2);
    check("busy_at_err", int'(busy), 0);
    strt_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (strt_cnv) strt_seen++;
    end
    check("strt_after_abort", strt_seen, 0);
    check("sb_empty_abort", sb.size(), 0);
    stall_ch = 4'd8;
    kill_model();

    // 5: go held high across two sweeps
    @(negedge clk);
    go = 1'b1;
    push_sweep(NCH);
    push_sweep(NCH);
    wait_done();
    check("held_go_busy_at_done", int'(busy), 0);
    @(negedge clk);
    check("held_go_idle_after_done", int'(busy), 0);
    check("held_go_no_strt", int'(strt_cnv), 0);
    @(negedge clk);
    check("held_go_restart", int'(busy), 1);
    go = 1'b0;
    wait_strt(1, k);
    check("held_go_strt_cycles", k, SCYC + 1);
    wait_done();
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("no_third_sweep", busy_seen, 0);
    check("sb_empty_held", sb.size(), 0);

    // 6: reset during WAIT of entry 3
    @(negedge clk);
    go = 1'b1;
    push_sweep(3);
    @(negedge clk);
    go = 1'b0;
    wait_strt(1, k);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      wait_strt(1, k);
    end
    check("entry3_chnnl", int'(chnnl), 2);
    @(negedge clk);
    @(negedge clk);
    check("busy_in_wait", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_rslt", int'(rslt), 0);
    check("rst_rslt_idx", int'(rslt_idx), 0);
    check("rst_chnnl", int'(chnnl), 1);
    check("rst_vld", int'(rslt_vld), 0);
    check("rst_done", int'(sweep_done), 0);
    check("sb_empty_reset", sb.size(), 0);
    rst_n = 1'b1;
    kill_model();
    @(negedge clk);
    go = 1'b1;
    push_sweep(NCH);
    @(negedge clk);
    go = 1'b0;
    wait_strt(1, k);
    check("restart_strt_cycles", k, SCYC + 1);
    check("restart_chnnl", int'(chnnl), 1);
    wait_done();
    repeat (3) @(negedge clk);
    check("sb_empty_final", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
